// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared pointer types and Gray/binary conversion helpers for the
//             asynchronous FIFO read and write control stages, plus the
//             encoding of the read-side output buffer occupancy.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend into this
    // width and truncate the result back to their own pointer width.
    localparam int c_ptr_max_w      = 32;
    localparam int c_fifo_addr_size = 3;

    typedef logic [c_ptr_max_w-1:0]    ptr_wide_t;
    typedef logic [c_fifo_addr_size:0] ptr_t;

    // Output buffer states are encoded as their occupancy so the state
    // register doubles as the word count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits leave the lower bits of the prefix-XOR unaffected,
    // so this is exact for any pointer width up to c_ptr_max_w.
    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b = g;
        for (int i = c_ptr_max_w - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Parameterized-width two-flop synchronizer for Gray pointers
//             crossing clock domains. Both stages clear on reset.
//  Ports    : clk  - destination clock
//             rst  - synchronous active-high reset
//             i_d  - asynchronous input vector
//             o_q  - synchronized output vector
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/rptr_empty.sv
`default_nettype none
// ============================================================================
//  Module   : rptr_empty
//  Purpose  : Read-side control of the asynchronous FIFO. Synchronizes the
//             Gray write pointer, maintains the read pointer, generates
//             empty / almost-empty flags, drives the memory read port and
//             presents data through a 2-entry first-word-fall-through buffer.
//  Ports    : rclk, rrst        - read clock, synchronous active-high reset
//             wptr_gray         - Gray write pointer (write clock domain)
//             rptr              - registered Gray read pointer to write side
//             raddr, ren        - memory read address / enable
//             rdata_mem         - memory read data, valid cycle after ren
//             rempty, raempty   - registered empty / almost-empty
//             rcount            - unread words still in memory
//             rvalid, rready    - output handshake
//             rdata             - output buffer head
//  Revision : 1.0  initial release
// ============================================================================
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 3,
    parameter int DATA_SIZE = 32,
    parameter int AEMPTY_TH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADDR_SIZE:0]   wptr_gray,
    output logic [ADDR_SIZE:0]   rptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic                 ren,
    input  logic [DATA_SIZE-1:0] rdata_mem,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDR_SIZE:0]   rcount,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int                 c_ptr_w      = ADDR_SIZE + 1;
    localparam logic [c_ptr_w-1:0] c_aempty_th  = c_ptr_w'(AEMPTY_TH);

    // ------------------------------------------------------------------
    // Write pointer synchronization
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] w_sync_wptr;

    sync_2ff #(
        .WIDTH (c_ptr_w)
    ) u_sync_wptr (
        .clk (rclk),
        .rst (rrst),
        .i_d (wptr_gray),
        .o_q (w_sync_wptr)
    );

    // ------------------------------------------------------------------
    // Read pointer and flags
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] r_rbin;
    logic [c_ptr_w-1:0] r_rptr;
    logic               r_rempty;
    logic               r_raempty;
    logic               r_pending;

    logic [c_ptr_w-1:0] w_rbin_next;
    logic [c_ptr_w-1:0] w_rbin_next_gray;
    logic [c_ptr_w-1:0] w_sync_wbin;
    logic [c_ptr_w-1:0] w_avail_next;
    logic               w_ren;
    logic               w_pop;
    logic               w_push;
    logic [2:0]         w_occ_after;

    buf_state_t           r_state;
    buf_state_t           w_state_next;
    logic [DATA_SIZE-1:0] r_buf0;
    logic [DATA_SIZE-1:0] r_buf1;
    logic [DATA_SIZE-1:0] w_buf0_next;
    logic [DATA_SIZE-1:0] w_buf1_next;

    assign w_pop  = rvalid & rready;
    assign w_push = r_pending;

    // Buffer occupancy once this cycle's pop and the in-flight word are
    // accounted for; a new read is issued only if its word will fit.
    // Never negative: a pop implies at least one stored word.
    assign w_occ_after = {1'b0, r_state} + {2'b00, r_pending} - {2'b00, w_pop};
    assign w_ren       = ~r_rempty & (w_occ_after < 3'd2);

    assign w_rbin_next      = r_rbin + {{ADDR_SIZE{1'b0}}, w_ren};
    assign w_rbin_next_gray = c_ptr_w'(bin2gray(ptr_wide_t'(w_rbin_next)));
    assign w_sync_wbin      = c_ptr_w'(gray2bin(ptr_wide_t'(w_sync_wptr)));
    assign w_avail_next     = w_sync_wbin - w_rbin_next;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin    <= '0;
            r_rptr    <= '0;
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
            r_pending <= 1'b0;
        end else begin
            r_rbin    <= w_rbin_next;
            r_rptr    <= w_rbin_next_gray;
            // Compared against the already-advanced pointer so empty rises
            // on the same edge the last word is claimed.
            r_rempty  <= (w_rbin_next_gray == w_sync_wptr);
            r_raempty <= (w_avail_next <= c_aempty_th);
            r_pending <= w_ren;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: head always in r_buf0, second word in r_buf1
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_buf0_next  = r_buf0;
        w_buf1_next  = r_buf1;
        case (r_state)
            BUF_EMPTY: begin
                if (w_push) begin
                    w_state_next = BUF_ONE;
                    w_buf0_next  = rdata_mem;
                end
            end
            BUF_ONE: begin
                if (w_push && w_pop) begin
                    w_buf0_next = rdata_mem;
                end else if (w_push) begin
                    w_state_next = BUF_TWO;
                    w_buf1_next  = rdata_mem;
                end else if (w_pop) begin
                    w_state_next = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                // Reads are throttled so no word arrives while full.
                if (w_pop) begin
                    w_state_next = BUF_ONE;
                    w_buf0_next  = r_buf1;
                end
            end
            default: begin
                w_state_next = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= BUF_EMPTY;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else begin
            r_state <= w_state_next;
            r_buf0  <= w_buf0_next;
            r_buf1  <= w_buf1_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rptr    = r_rptr;
    assign raddr   = r_rbin[ADDR_SIZE-1:0];
    assign ren     = w_ren;
    assign rempty  = r_rempty;
    assign raempty = r_raempty;
    assign rcount  = w_sync_wbin - r_rbin;
    assign rvalid  = (r_state != BUF_EMPTY);
    assign rdata   = r_buf0;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rptr_empty
//  Purpose  : Self-checking bench for rptr_empty. The stimulus thread plays
//             the write side (memory contents + Gray write pointer) and
//             queues the expected words and read addresses; a monitor
//             pops and compares whenever the DUT reads memory or hands a
//             word to the consumer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rptr_empty;

    logic        rclk;
    logic        rrst;
    logic [3:0]  wptr_gray;
    logic [3:0]  rptr;
    logic [2:0]  raddr;
    logic        ren;
    logic [31:0] rdata_mem;
    logic        rempty;
    logic        raempty;
    logic [3:0]  rcount;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    rptr_empty #(
        .ADDR_SIZE (3),
        .DATA_SIZE (32),
        .AEMPTY_TH (1)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr_gray (wptr_gray),
        .rptr      (rptr),
        .raddr     (raddr),
        .ren       (ren),
        .rdata_mem (rdata_mem),
        .rempty    (rempty),
        .raempty   (raempty),
        .rcount    (rcount),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Memory model: registered read port.
    logic [31:0] mem [0:7];
    always @(posedge rclk) begin
        if (ren) rdata_mem <= mem[raddr];
    end

    int checks   = 0;
    int failures = 0;
    int wtot     = 0;
    int rtot     = 0;
    logic prev_ren = 1'b0;

    logic [31:0] exp_data [$];
    logic [2:0]  exp_addr [$];

    function automatic logic [3:0] g4(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    // Write side: store the next word and advance the Gray write pointer.
    task automatic wr_word();
        logic [31:0] d;
        d = 32'hC0DE_0000 | 32'(wtot);
        mem[wtot % 8] = d;
        exp_data.push_back(d);
        exp_addr.push_back(3'(wtot % 8));
        wtot++;
        wptr_gray = g4(wtot);
    endtask

    task automatic drain(input string name, input int bound);
        int c;
        c = 0;
        while (exp_data.size() != 0 && c < bound) begin
            step();
            c++;
        end
        checks++;
        if (exp_data.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_data.size());
        end
        repeat (3) step();
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge rclk) begin
        if (rrst) begin
            prev_ren = 1'b0;
        end else begin
            if (prev_ren) chk("rptr", 32'(rptr), 32'(g4(rtot)));
            if (ren) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got raddr %0d expected none", raddr);
                end else begin
                    chk("raddr", 32'(raddr), 32'(exp_addr.pop_front()));
                end
                rtot++;
            end
            prev_ren = ren;
            if (rvalid && rready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none", rdata);
                end else begin
                    chk("rdata", rdata, exp_data.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        rrst      = 1'b1;
        wptr_gray = '0;
        rready    = 1'b0;

        // Reset
        repeat (2) begin
            @(posedge rclk);
            @(negedge rclk);
            chk("rst_rempty",  32'(rempty),  32'd1);
            chk("rst_raempty", 32'(raempty), 32'd1);
            chk("rst_rvalid",  32'(rvalid),  32'd0);
            chk("rst_ren",     32'(ren),     32'd0);
            chk("rst_rptr",    32'(rptr),    32'd0);
            chk("rst_rcount",  32'(rcount),  32'd0);
            chk("rst_rdata",   rdata,        32'd0);
        end
        step();
        rrst = 1'b0;

        // Single word: latency through synchronizer, flag and buffer
        rready = 1'b1;
        wr_word();
        for (int e = 1; e <= 6; e++) begin
            @(posedge rclk);
            @(negedge rclk);
            case (e)
                1, 2: chk("single_rempty_hold", 32'(rempty), 32'd1);
                3: begin
                    chk("single_rempty_fall", 32'(rempty), 32'd0);
                    chk("single_ren",         32'(ren),    32'd1);
                    chk("single_rcount",      32'(rcount), 32'd1);
                end
                4: begin
                    chk("single_rempty_rise", 32'(rempty), 32'd1);
                    chk("single_ren_off",     32'(ren),    32'd0);
                    chk("single_rvalid_lat",  32'(rvalid), 32'd0);
                end
                5: begin
                    chk("single_rvalid", 32'(rvalid), 32'd1);
                    chk("single_head",   rdata,       32'hC0DE_0000);
                end
                default: chk("single_rvalid_drop", 32'(rvalid), 32'd0);
            endcase
        end

        // Burst of 8 with backpressure
        step();
        rready = 1'b0;
        for (int i = 0; i < 8; i++) wr_word();
        repeat (12) step();
        @(negedge rclk);
        chk("burst_rcount",  32'(rcount),  32'd6);
        chk("burst_ren",     32'(ren),     32'd0);
        chk("burst_rvalid",  32'(rvalid),  32'd1);
        chk("burst_head",    rdata,        32'hC0DE_0001);
        chk("burst_raempty", 32'(raempty), 32'd0);
        chk("burst_rptr",    32'(rptr),    32'd2);
        repeat (3) step();
        chk("burst_head_stable", rdata, 32'hC0DE_0001);
        rready = 1'b1;
        drain("burst", 40);
        chk("burst_rempty_end", 32'(rempty), 32'd1);
        chk("burst_rvalid_end", 32'(rvalid), 32'd0);

        // Streaming across address and pointer wrap (24 words total)
        for (int c = 0; c < 300 && (wtot < 24 || exp_data.size() != 0); c++) begin
            if (wtot < 24 && (wtot - rtot) < 8) wr_word();
            step();
        end
        drain("wrap", 20);
        chk("wrap_rptr",   32'(rptr),   32'(4'd12));
        chk("wrap_rcount", 32'(rcount), 32'd0);
        chk("wrap_rempty", 32'(rempty), 32'd1);

        // Almost-empty: 5 words, 2 held in buffer, 3 left in memory
        rready = 1'b0;
        for (int i = 0; i < 5; i++) wr_word();
        repeat (10) step();
        chk("ae3_rcount",  32'(rcount),  32'd3);
        chk("ae3_raempty", 32'(raempty), 32'd0);
        chk("ae3_rempty",  32'(rempty),  32'd0);
        for (int p = 0; p < 3; p++) begin
            rready = 1'b1;
            step();
            rready = 1'b0;
            repeat (4) step();
            if (p == 1) begin
                chk("ae1_rcount",  32'(rcount),  32'd1);
                chk("ae1_raempty", 32'(raempty), 32'd1);
                chk("ae1_rempty",  32'(rempty),  32'd0);
            end
        end
        chk("ae0_rcount", 32'(rcount), 32'd0);
        chk("ae0_rempty", 32'(rempty), 32'd1);
        rready = 1'b1;
        drain("ae", 20);

        // Reset mid-stream
        for (int i = 0; i < 6; i++) wr_word();
        begin
            int c;
            c = 0;
            while (exp_data.size() > 4 && c < 50) begin
                step();
                c++;
            end
            chk("midrst_reach", 32'(exp_data.size() <= 4), 32'd1);
        end
        rrst      = 1'b1;
        wptr_gray = '0;
        exp_data.delete();
        exp_addr.delete();
        wtot = 0;
        rtot = 0;
        @(posedge rclk);
        @(negedge rclk);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rptr",   32'(rptr),   32'd0);
        chk("midrst_rempty", 32'(rempty), 32'd1);
        chk("midrst_ren",    32'(ren),    32'd0);
        step();
        rrst = 1'b0;
        repeat (6) step();
        chk("postrst_rempty", 32'(rempty), 32'd1);
        chk("postrst_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < 3; i++) wr_word();
        drain("postrst", 30);
        chk("postrst_rptr", 32'(rptr), 32'(g4(3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rptr_empty.md
# rptr_empty

Read-side control stage of the asynchronous FIFO, running entirely in the read clock domain. It consumes the Gray-coded write pointer produced by the write-pointer/full stage, synchronizes it, generates the read pointer and empty/almost-empty flags, drives the dual-clock memory's read port, and presents data to the consumer through a 2-entry first-word-fall-through output buffer with a valid/ready handshake. Its Gray read pointer is returned to the write domain for full detection.

## Interface
- ADDR_SIZE, 3, memory address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits (extra wrap bit)
- DATA_SIZE, 32, word width
- AEMPTY_TH, 1, raempty asserts when unread words in memory ≤ this value
- rclk  input  1  read-domain clock
- rrst  input  1  reset, synchronous, active-high
- wptr_gray  input  ADDR_SIZE+1  Gray write pointer from the write domain (asynchronous to rclk)
- rptr  output  ADDR_SIZE+1  registered Gray read pointer to the write domain
- raddr  output  ADDR_SIZE  memory read address
- ren  output  1  memory read enable
- rdata_mem  input  DATA_SIZE  memory read data, valid the cycle after ren
- rempty  output  1  registered: no unread words in memory
- raempty  output  1  registered almost-empty
- rcount  output  ADDR_SIZE+1  unread words in memory (excludes output buffer)
- rvalid  output  1  output buffer head valid
- rready  input  1  consumer accepts head
- rdata  output  DATA_SIZE  output buffer head

## Operation
- wptr_gray passes through a 2-flop synchronizer → sync_wptr; no other logic touches wptr_gray.
- Binary read pointer rbin; rbin_next = rbin + ren, modulo 2^(ADDR_SIZE+1). raddr = rbin[ADDR_SIZE-1:0] (combinational from rbin). rptr <= bin2gray(rbin_next).
- rempty <= (bin2gray(rbin_next) == sync_wptr). rcount = gray2bin(sync_wptr) − rbin, modulo 2^(ADDR_SIZE+1). raempty <= ((gray2bin(sync_wptr) − rbin_next) ≤ AEMPTY_TH).
- pending flag: pending <= ren (one read in flight). On the cycle pending=1, rdata_mem is written into the output buffer.
- Output buffer: 2-entry FIFO, occupancy occ ∈ {0,1,2}, states EMPTY/ONE/TWO. pop = rvalid & rready. push = pending.
  - EMPTY: push → ONE.
  - ONE: push & !pop → TWO; pop & !push → EMPTY; push & pop → ONE, new word becomes head.
  - TWO: pop → ONE (second entry becomes head). push never occurs in TWO (guaranteed by ren rule).
- ren = !rempty & (occ + pending − pop < 2). This yields one word per cycle in steady state with rready held high.
- rvalid = (occ != 0); rdata = head entry. rdata stable while rvalid & !rready.
- Gray pointers make the comparison safe against multi-bit skew; empty is pessimistic (may stay high extra cycles), never optimistic.

## Timing
- Reset values: rptr=0, raddr=0, ren=0, rempty=1, raempty=1, rcount=0, rvalid=0, rdata=0; sync flops, rbin, pending, occ cleared.
- Reset mid-operation: all state cleared on the rrst edge; rdata_mem on the cycle after reset is discarded (pending=0); an in-flight word is lost.
- Write-to-read latency: wptr_gray change before edge 1 → sync at edges 1–2 → rempty falls at edge 3 → ren during cycle 3 → pending at edge 4 → rvalid at edge 5.
- rempty rises at the same edge rbin advances onto sync_wptr; ren deasserts in that cycle.
- Wrap-around: rbin wraps from 2^(ADDR_SIZE+1)−1 to 0; raddr wraps at 2^ADDR_SIZE; flags remain correct across both.
- Simultaneous pop and push in ONE: head replaced in same edge, rvalid stays 1.

## Structure
- Shared package fifo_pkg: bin2gray and gray2bin functions parameterized on pointer width, ptr_t typedef; shared with the write-pointer/full stage.
- One sub-module: sync_2ff (parameterized-width two-flop synchronizer, reset to 0), instantiated for wptr_gray; reused by the write stage for rptr.

## Test plan
- Reset: hold rrst 2 cycles, wptr_gray=0 → rempty=1, raempty=1, rvalid=0, ren=0, rptr=0 throughout.
- Single word: wptr_gray 0→1, rready=1 → rempty falls at edge 3, ren=1 raddr=0 in cycle 3, rvalid=1 at edge 5 with memory word 0; rptr=1, rempty=1 afterwards.
- Burst with backpressure: 8 words written, rready=0 → occ reaches 2, ren stops after 2 reads, rcount=6; raise rready → words 0..7 in order, one per cycle, no duplicates.
- Wrap-around: 20 words total with rready=1 → raddr sequence 0..7,0..7,0..3; rptr Gray sequence matches bin2gray(1..20 mod 16).
- Almost-empty: AEMPTY_TH=1, 3 unread words → raempty=0; after reads leave 1 → raempty=1, rempty=0; after last → rempty=1.
- Reset mid-burst: assert rrst while pending=1 and occ=2 → next cycle rvalid=0, rptr=0, rempty reflects only resynchronized wptr_gray; no stale word emitted.
